// File: rtl/spi_frame_mirror_pkg.sv
// ============================================================
// spi_frame_mirror_pkg : shared types for the SPI frame mirror
// Revision 1.0
// ============================================================
`default_nettype none

`define SFM_FRAME_T(LANES, BITS) struct packed { logic [(LANES)-1:0][(BITS)-1:0] lanes; }

package spi_frame_mirror_pkg;

   typedef enum logic [1:0] {
      MODE_MIRROR     = 2'b00,
      MODE_REPLAY     = 2'b01,
      MODE_REPLAY_INV = 2'b10
   } mode_e;

   typedef enum logic [2:0] {
      TX_IDLE     = 3'd0,
      TX_CS_SETUP = 3'd1,
      TX_SHIFT    = 3'd2,
      TX_CS_HOLD  = 3'd3,
      TX_GAP      = 3'd4
   } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_frame_fifo.sv
// ============================================================
// spi_frame_fifo : first-word-fall-through frame FIFO
// Revision 1.0
// ============================================================
`default_nettype none

module spi_frame_fifo #(
   parameter int G_DEPTH = 4,
   parameter int G_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_push,
   input  logic [G_WIDTH-1:0]             i_wdata,
   input  logic                           i_pop,
   output logic [G_WIDTH-1:0]             o_rdata,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(G_DEPTH+1)-1:0]   o_level
);

   localparam int c_ptr_w = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
   localparam int c_lvl_w = $clog2(G_DEPTH+1);

   logic [G_DEPTH-1:0][G_WIDTH-1:0] mem_q, mem_d;
   logic [c_ptr_w-1:0]              wr_q, wr_d, rd_q, rd_d;
   logic [c_lvl_w-1:0]              lvl_q, lvl_d;
   logic                            do_push, do_pop;

   function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_w'(G_DEPTH-1)) ? '0 : p + c_ptr_w'(1);
   endfunction

   assign o_full  = (lvl_q == c_lvl_w'(G_DEPTH));
   assign o_empty = (lvl_q == '0);
   assign o_level = lvl_q;
   assign o_rdata = mem_q[rd_q];

   // A pop frees the slot in the same cycle, so push-while-full succeeds.
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (do_push) begin
         mem_d[wr_q] = i_wdata;
         wr_d        = next_ptr(wr_q);
      end
      if (do_pop) begin
         rd_d = next_ptr(rd_q);
      end
      if (do_push && !do_pop) begin
         lvl_d = lvl_q + c_lvl_w'(1);
      end else if (!do_push && do_pop) begin
         lvl_d = lvl_q - c_lvl_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_frame_mirror.sv
// ============================================================
// spi_frame_mirror : multi-lane SPI mirror / frame replay engine
// Revision 1.0
// ============================================================
`default_nettype none

module spi_frame_mirror
   import spi_frame_mirror_pkg::*;
#(
   parameter int G_SPI_SIZE    = 4,
   parameter int G_FRAME_BITS  = 8,
   parameter int G_FIFO_DEPTH  = 4,
   parameter int G_CLK_DIV     = 4,
   parameter int G_SYNC_STAGES = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [1:0]                          i_mode,
   input  logic                                i_tx_en,
   input  logic                                i_spi_clk,
   input  logic                                i_spi_cs_n,
   input  logic [G_SPI_SIZE-1:0]               i_spi_di,
   output logic                                o_spi_clk,
   output logic                                o_spi_cs_n,
   output logic [G_SPI_SIZE-1:0]               o_spi_do,
   output logic [$clog2(G_FIFO_DEPTH+1)-1:0]   o_fifo_level,
   output logic [15:0]                         o_frame_cnt,
   output logic                                o_overflow,
   output logic                                o_frame_err,
   output logic                                o_busy
);

   localparam int c_in_w    = G_SPI_SIZE + 2;
   localparam int c_frame_w = G_SPI_SIZE * G_FRAME_BITS;
   localparam int c_bit_w   = $clog2(G_FRAME_BITS+1);
   localparam int c_div_w   = $clog2(G_CLK_DIV+1);
   localparam int c_half_w  = $clog2(2*G_FRAME_BITS+1);
   localparam logic [c_in_w-1:0] c_sync_rst = c_in_w'(1) << G_SPI_SIZE;

   typedef `SFM_FRAME_T(G_SPI_SIZE, G_FRAME_BITS) frame_t;

   logic [G_SYNC_STAGES-1:0][c_in_w-1:0] sync_q, sync_d;
   logic                  s_clk, s_cs_n;
   logic [G_SPI_SIZE-1:0] s_di;
   logic                  prev_clk_q, prev_cs_n_q;
   logic                  clk_rise, cs_rise, mirror_mode;

   frame_t                cap_q, cap_d, tx_load, tx_frame_q;
   logic [c_bit_w-1:0]    bit_cnt_q, bit_cnt_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overflow_q, overflow_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  push, pop, fifo_full, fifo_empty;
   logic [c_frame_w-1:0]  fifo_rdata;

   tx_state_e             tx_state_q;
   logic [c_div_w-1:0]    div_q;
   logic [c_half_w-1:0]   half_q;
   logic                  spi_clk_q, spi_cs_n_q;
   logic [G_SPI_SIZE-1:0] spi_do_q;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {i_spi_clk, i_spi_cs_n, i_spi_di};
      for (int i = 1; i < G_SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign {s_clk, s_cs_n, s_di} = sync_q[G_SYNC_STAGES-1];
   assign clk_rise    = s_clk && !prev_clk_q;
   assign cs_rise     = s_cs_n && !prev_cs_n_q;
   assign mirror_mode = (i_mode == MODE_MIRROR);

   always_comb begin
      cap_d       = cap_q;
      bit_cnt_d   = bit_cnt_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      if (mirror_mode) begin
         bit_cnt_d = '0;
      end else if (cs_rise && (bit_cnt_q != '0)) begin
         frame_err_d = 1'b1;
         bit_cnt_d   = '0;
      end else if (clk_rise && !s_cs_n) begin
         for (int l = 0; l < G_SPI_SIZE; l++) begin
            cap_d.lanes[l] = {cap_q.lanes[l][G_FRAME_BITS-2:0], s_di[l]};
         end
         if (bit_cnt_q == c_bit_w'(G_FRAME_BITS-1)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + c_bit_w'(1);
         end
      end
   end

   assign pop         = (tx_state_q == TX_IDLE) && i_tx_en && !mirror_mode && !fifo_empty;
   assign overflow_d  = overflow_q | (push & fifo_full & ~pop);
   assign frame_cnt_d = frame_cnt_q + 16'(push && (!fifo_full || pop));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= {G_SYNC_STAGES{c_sync_rst}};
         prev_clk_q  <= 1'b0;
         prev_cs_n_q <= 1'b1;
         cap_q       <= '0;
         bit_cnt_q   <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         sync_q      <= sync_d;
         prev_clk_q  <= s_clk;
         prev_cs_n_q <= s_cs_n;
         cap_q       <= cap_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   spi_frame_fifo #(
      .G_DEPTH (G_FIFO_DEPTH),
      .G_WIDTH (c_frame_w)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (push),
      .i_wdata (cap_d),
      .i_pop   (pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (o_fifo_level)
   );

   // Inversion is applied once at pop time, so the mode is only sampled in IDLE.
   assign tx_load = frame_t'((i_mode == MODE_REPLAY_INV) ? ~fifo_rdata : fifo_rdata);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         div_q      <= '0;
         half_q     <= '0;
         tx_frame_q <= '0;
         spi_clk_q  <= 1'b0;
         spi_cs_n_q <= 1'b1;
         spi_do_q   <= '0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               div_q  <= '0;
               half_q <= '0;
               if (pop) begin
                  tx_frame_q <= tx_load;
                  spi_clk_q  <= 1'b0;
                  spi_cs_n_q <= 1'b0;
                  for (int l = 0; l < G_SPI_SIZE; l++) begin
                     spi_do_q[l] <= tx_load.lanes[l][G_FRAME_BITS-1];
                  end
                  tx_state_q <= TX_CS_SETUP;
               end else if (mirror_mode) begin
                  {spi_clk_q, spi_cs_n_q, spi_do_q} <= {s_clk, s_cs_n, s_di};
               end else begin
                  spi_clk_q  <= 1'b0;
                  spi_cs_n_q <= 1'b1;
                  spi_do_q   <= '0;
               end
            end
            TX_CS_SETUP: begin
               if (div_q == c_div_w'(G_CLK_DIV-1)) begin
                  div_q      <= '0;
                  spi_clk_q  <= 1'b1;
                  tx_state_q <= TX_SHIFT;
               end else begin
                  div_q <= div_q + c_div_w'(1);
               end
            end
            TX_SHIFT: begin
               if (div_q == c_div_w'(G_CLK_DIV-1)) begin
                  div_q <= '0;
                  if (half_q == c_half_w'(2*G_FRAME_BITS-1)) begin
                     tx_state_q <= TX_CS_HOLD;
                  end else begin
                     half_q    <= half_q + c_half_w'(1);
                     spi_clk_q <= ~spi_clk_q;
                     if (spi_clk_q) begin
                        for (int l = 0; l < G_SPI_SIZE; l++) begin
                           tx_frame_q.lanes[l] <= {tx_frame_q.lanes[l][G_FRAME_BITS-2:0], 1'b0};
                           spi_do_q[l]         <= tx_frame_q.lanes[l][G_FRAME_BITS-2];
                        end
                     end
                  end
               end else begin
                  div_q <= div_q + c_div_w'(1);
               end
            end
            TX_CS_HOLD: begin
               if (div_q == c_div_w'(G_CLK_DIV-1)) begin
                  div_q      <= '0;
                  spi_cs_n_q <= 1'b1;
                  tx_state_q <= TX_GAP;
               end else begin
                  div_q <= div_q + c_div_w'(1);
               end
            end
            TX_GAP: begin
               if (div_q == c_div_w'(G_CLK_DIV-1)) begin
                  div_q      <= '0;
                  tx_state_q <= TX_IDLE;
               end else begin
                  div_q <= div_q + c_div_w'(1);
               end
            end
            default: begin
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   assign o_spi_clk   = spi_clk_q;
   assign o_spi_cs_n  = spi_cs_n_q;
   assign o_spi_do    = spi_do_q;
   assign o_frame_cnt = frame_cnt_q;
   assign o_overflow  = overflow_q;
   assign o_frame_err = frame_err_q;
   assign o_busy      = (tx_state_q != TX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_mirror.sv
// ============================================================
// tb_spi_frame_mirror : randomized self-checking bench
// Revision 1.0
// ============================================================
`default_nettype none

module tb_spi_frame_mirror;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic        tx_en;
   logic        spi_clk, spi_cs_n;
   logic [3:0]  spi_di;
   logic        o_spi_clk, o_spi_cs_n;
   logic [3:0]  o_spi_do;
   logic [2:0]  o_fifo_level;
   logic [15:0] o_frame_cnt;
   logic        o_overflow, o_frame_err, o_busy;

   spi_frame_mirror #(
      .G_SPI_SIZE    (4),
      .G_FRAME_BITS  (8),
      .G_FIFO_DEPTH  (4),
      .G_CLK_DIV     (4),
      .G_SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_mode       (mode),
      .i_tx_en      (tx_en),
      .i_spi_clk    (spi_clk),
      .i_spi_cs_n   (spi_cs_n),
      .i_spi_di     (spi_di),
      .o_spi_clk    (o_spi_clk),
      .o_spi_cs_n   (o_spi_cs_n),
      .o_spi_do     (o_spi_do),
      .o_fifo_level (o_fifo_level),
      .o_frame_cnt  (o_frame_cnt),
      .o_overflow   (o_overflow),
      .o_frame_err  (o_frame_err),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Output monitor: decodes transmitted frames at the pin level.
   logic        mon_en = 1'b0;
   int          cyc = 0, busy_cycles = 0, err_pulses = 0, err_long = 0, gap_bad = 0;
   logic [31:0] rx_frames[$];
   int          rx_edges[$];
   int          rx_cslow[$];

   initial begin
      logic [3:0][7:0] mon_bits;
      int   mon_edges, mon_cslow, last_edge;
      logic prev_oclk, prev_ocs, prev_err;
      mon_bits = '0; mon_edges = 0; mon_cslow = 0; last_edge = 0;
      prev_oclk = 1'b0; prev_ocs = 1'b1; prev_err = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            mon_bits = '0; mon_edges = 0; mon_cslow = 0;
            prev_oclk = 1'b0; prev_ocs = 1'b1; prev_err = 1'b0;
         end else begin
            if (o_busy) busy_cycles++;
            if (o_frame_err) begin
               err_pulses++;
               if (prev_err) err_long++;
            end
            if (!o_spi_cs_n) begin
               mon_cslow++;
               if (o_spi_clk && !prev_oclk) begin
                  if (mon_en && mon_edges > 0 && (cyc - last_edge) != 8) gap_bad++;
                  last_edge = cyc;
                  mon_edges++;
                  for (int l = 0; l < 4; l++) mon_bits[l] = {mon_bits[l][6:0], o_spi_do[l]};
               end
            end else if (!prev_ocs) begin
               if (mon_en) begin
                  rx_frames.push_back(mon_bits);
                  rx_edges.push_back(mon_edges);
                  rx_cslow.push_back(mon_cslow);
               end
               mon_edges = 0;
               mon_cslow = 0;
            end
            prev_oclk = o_spi_clk;
            prev_ocs  = o_spi_cs_n;
            prev_err  = o_frame_err;
         end
      end
   end

   // Reference model: what should come out, in order, and the counters.
   logic [31:0] exp_q[$];
   int          rx_rd = 0;
   logic [15:0] exp_cnt = '0;
   int          exp_level = 0;
   logic        exp_ovf = 1'b0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] f, input int nbits);
      logic [3:0][7:0] fr;
      fr = f;
      spi_cs_n = 1'b0;
      spi_clk  = 1'b0;
      tick(3);
      for (int b = 0; b < nbits; b++) begin
         for (int l = 0; l < 4; l++) spi_di[l] = fr[l][7-b];
         tick(3);
         spi_clk = 1'b1;
         tick(3);
         spi_clk = 1'b0;
      end
      tick(3);
      spi_cs_n = 1'b1;
      tick(6);
   endtask

   // Live replay: no overflow expected, every frame goes straight to the output queue.
   task automatic send_live(input logic [31:0] f, input logic inv);
      send_frame(f, 8);
      exp_cnt++;
      exp_q.push_back(inv ? ~f : f);
   endtask

   // Buffered capture with transmit disabled: the level is fully predictable.
   task automatic send_held(input logic [31:0] f);
      send_frame(f, 8);
      if (exp_level < 4) begin
         exp_level++;
         exp_cnt++;
         exp_q.push_back(f);
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic drain(input int n_new);
      int target, budget;
      logic [31:0] e;
      target = rx_rd + n_new;
      budget = 0;
      while ((rx_frames.size() < target || o_busy || o_fifo_level != 0) && budget < 4000) begin
         tick(1);
         budget++;
      end
      check("drain_done", 32'(budget < 4000), 32'd1);
      for (int i = 0; i < n_new; i++) begin
         e = 32'hDEAD_BEEF;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (rx_rd < rx_frames.size()) begin
            check("rx_frame", rx_frames[rx_rd], e);
            check("rx_edges", 32'(rx_edges[rx_rd]), 32'd8);
            check("rx_cs_low", 32'(rx_cslow[rx_rd]), 32'd72);
         end else begin
            check("rx_missing", 32'(rx_frames.size()), 32'(target));
         end
         rx_rd++;
      end
      exp_level = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  prev_v, v;
      logic [31:0] f;
      int          b0, e0, l0;
      logic [15:0] c0;

      rst = 1'b1; mode = 2'b00; tx_en = 1'b0;
      spi_clk = 1'b0; spi_cs_n = 1'b1; spi_di = 4'h0;
      tick(3);
      check("rst_spi_clk", 32'(o_spi_clk), 32'd0);
      check("rst_cs_n", 32'(o_spi_cs_n), 32'd1);
      check("rst_do", 32'(o_spi_do), 32'd0);
      check("rst_level", 32'(o_fifo_level), 32'd0);
      check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      check("rst_frame_err", 32'(o_frame_err), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      rst = 1'b0;
      tick(4);

      // Mirror: outputs follow inputs exactly three cycles later.
      prev_v = 6'b010000;
      for (int i = 0; i < 8; i++) begin
         v = 6'($urandom);
         if (i == 0) v = 6'b001010;
         if (v == prev_v) v = ~v;
         {spi_clk, spi_cs_n, spi_di} = v;
         tick(2);
         check("mirror_early", 32'({o_spi_clk, o_spi_cs_n, o_spi_do}), 32'(prev_v));
         tick(1);
         check("mirror_lat", 32'({o_spi_clk, o_spi_cs_n, o_spi_do}), 32'(v));
         prev_v = v;
      end
      spi_clk = 1'b0; spi_cs_n = 1'b1; spi_di = 4'h0;
      tick(6);
      check("mirror_no_capture", 32'(o_frame_cnt), 32'd0);
      mon_en = 1'b1;

      // Replay, plain.
      mode = 2'b01; tx_en = 1'b1;
      b0 = busy_cycles;
      f = $urandom; f[7:0] = 8'b1011_0011;
      send_live(f, 1'b0);
      send_live($urandom, 1'b0);
      send_live($urandom, 1'b0);
      drain(3);
      check("replay_busy", 32'(busy_cycles - b0), 32'(3 * 76));
      check("replay_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      check("replay_ovf", 32'(o_overflow), 32'd0);

      // Replay, inverted.
      mode = 2'b10;
      b0 = busy_cycles;
      f = $urandom; f[7:0] = 8'b1011_0011;
      send_live(f, 1'b1);
      send_live($urandom, 1'b1);
      drain(2);
      check("inv_busy", 32'(busy_cycles - b0), 32'(2 * 76));
      check("inv_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

      // Overflow with transmit held off; reserved mode acts as plain replay.
      mode = 2'b11; tx_en = 1'b0;
      for (int i = 0; i < 5; i++) send_held($urandom);
      check("ovf_level", 32'(o_fifo_level), 32'(exp_level));
      check("ovf_flag", 32'(o_overflow), 32'(exp_ovf));
      check("ovf_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      b0 = busy_cycles;
      tx_en = 1'b1;
      drain(4);
      check("ovf_busy", 32'(busy_cycles - b0), 32'(4 * 76));
      check("ovf_sticky", 32'(o_overflow), 32'd1);
      check("ovf_level_empty", 32'(o_fifo_level), 32'd0);

      // Truncated frame.
      mode = 2'b01; tx_en = 1'b0;
      e0 = err_pulses; l0 = err_long; c0 = o_frame_cnt;
      send_frame($urandom, 5);
      check("err_pulses", 32'(err_pulses - e0), 32'd1);
      check("err_single", 32'(err_long - l0), 32'd0);
      check("err_cnt", 32'(o_frame_cnt), 32'(c0));
      check("err_level", 32'(o_fifo_level), 32'd0);
      send_held($urandom);
      check("after_err_level", 32'(o_fifo_level), 32'(exp_level));
      check("after_err_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      tx_en = 1'b1;
      drain(1);

      // Reset in the middle of a shift.
      tx_en = 1'b0;
      send_frame($urandom, 8);
      send_frame($urandom, 8);
      tx_en = 1'b1;
      b0 = 0;
      while (!(o_busy && o_spi_clk) && b0 < 500) begin
         tick(1);
         b0++;
      end
      check("shift_reached", 32'(b0 < 500), 32'd1);
      tick(2);
      rst = 1'b1;
      tick(1);
      check("mid_rst_cs_n", 32'(o_spi_cs_n), 32'd1);
      check("mid_rst_clk", 32'(o_spi_clk), 32'd0);
      check("mid_rst_level", 32'(o_fifo_level), 32'd0);
      check("mid_rst_ovf", 32'(o_overflow), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd0);
      check("mid_rst_cnt", 32'(o_frame_cnt), 32'd0);
      rst = 1'b0;
      tick(10);
      check("post_rst_idle", 32'(o_busy), 32'd0);
      check("post_rst_no_frames", 32'(rx_frames.size()), 32'(rx_rd));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
